cond_unit_banked: RTL and testbench
===================================

# cond_unit_banked

Parametrised conditional-execution unit for the single-cycle ARM datapath. It keeps one registered NZVC flag bank per hardware context and evaluates each instruction's condition against the stored flags of its own context. An optional IT-style sequencer predicates the next 1..MAX_IT instructions of a context. It gates PCSrc, RegWrite and MemWrite exactly where the controller's decoded PCS/RegW/MemW meet the datapath.

## Interface
- NCTX, 2: number of flag banks / contexts (≥1)
- CTX_W, 1: width of context select; 2**CTX_W ≥ NCTX
- MAX_IT, 4: maximum IT block length (1..8)

- CLK  in  1  clock, rising edge
- RESET_N  in  1  reset; one clock, asynchronous active-low reset
- Valid  in  1  instruction present this cycle
- Ctx  in  CTX_W  context of the instruction; values ≥ NCTX are treated as Valid=0
- Cond  in  4  instruction condition code
- ALUFlags  in  4  {N,Z,V,C} from ALU, same cycle
- FlagW  in  2  [1]=update NZ, [0]=update VC
- PCS, RegW, MemW  in  1 each  decoded unconditional enables
- ITStart  in  1  instruction is an IT directive (requires COND_IT_EN)
- ITCond  in  4  base condition of IT block
- ITLen  in  4  block length; 0 = no-op; >MAX_IT clamps to MAX_IT
- ITThen  in  MAX_IT  bit i: 1 = slot i uses ITCond, 0 = inverted ITCond
- PCSrc, RegWrite, MemWrite  out  1 each  gated enables
- CondEx  out  1  condition passed
- ITActive  out  1  IT slots remain
- FlagsOut  out  4  stored {N,Z,V,C} of bank Ctx

## Operation
- Effective condition (EC) is Cond, or the current IT slot's condition when ITActive and Ctx == ITCtx.
  - Inverted slot condition = ITCond with bit0 flipped.
  - Inverting 1110 yields 1111.
- CondEx is evaluated on bank[Ctx] with the standard ARM encodings:
  - 0000 EQ … 1101 LE.
  - 1110 always.
  - 1111 never (CondEx=0).
- Outputs:
  - PCSrc = Valid & CondEx & PCS.
  - RegWrite = Valid & CondEx & RegW.
  - MemWrite = Valid & CondEx & MemW.
  - Forced 0 for ITStart instructions.
- Flag write: on a rising edge with Valid & CondEx & ~ITStart:
  - FlagW[1] loads bank[Ctx].NZ ← ALUFlags[3:2].
  - FlagW[0] loads bank[Ctx].VC ← ALUFlags[1:0].
  - Other banks are untouched.
- IT state: ITCtx, ITCond, a mask and a remaining-count (0..MAX_IT).
  - IDLE → ACTIVE: Valid & ITStart & ITLen≠0 loads the state. Ctx is captured as ITCtx, and remaining = min(ITLen, MAX_IT).
  - ACTIVE, Valid & Ctx==ITCtx & ~ITStart: consume one slot (shift mask, remaining−1), whether or not it passes.
  - ACTIVE → IDLE when remaining reaches 0, or when a slot instruction asserts PCSrc (taken branch flushes the rest).
  - ITStart while ACTIVE restarts with the new block; ITLen=0 while ACTIVE clears to IDLE.
  - Instructions of other contexts use their own Cond and do not consume slots.
- ITActive = (remaining ≠ 0).

## Timing
- All outputs are combinational from inputs plus registered state, with zero latency.
- Flag and IT-state updates take effect on the next rising edge. The instruction writing flags sees the old flags.
- While RESET_N=0, state is held at reset and all outputs are 0:
  - every bank = 0000
  - remaining = 0
  - ITCtx = 0
- Asynchronous assertion mid-block discards the IT block immediately.
- Deassertion is synchronised by the system. The first edge after release may update state.
- A flag write and a slot consume in the same cycle both occur.

## Configuration
- COND_IT_EN defined: IT sequencer as above.
- COND_IT_EN undefined:
  - no IT registers; ITActive = 0
  - ITStart, ITCond, ITLen, ITThen ignored
  - ITStart is treated as 0, so the instruction executes normally on its Cond

## Test plan
- Reset, then Valid, Ctx=0, Cond=0000, RegW=1 → FlagsOut=0000, CondEx=0, RegWrite=0; Cond=1110 → RegWrite=1; Cond=1111 → RegWrite=0.
- Ctx=0, Cond=1110, FlagW=11, ALUFlags=0100 → next cycle Ctx=0, EQ passes and FlagsOut=0100; Ctx=1, EQ fails and FlagsOut=0000.
- Bank0 NZVC=1000, Cond=1011 (LT) with FlagW=01, ALUFlags=0011, MemW=1 → MemWrite=1 that cycle; next cycle bank0=1011, GE (1010) passes.
- (COND_IT_EN) bank0 Z=1, ITStart ITCond=0000 ITLen=3 ITThen=101 → next three Ctx=0 RegW instructions give RegWrite 1,0,1, ITActive 1,1,1 then 0.
- (COND_IT_EN) same IT block, interleave Ctx=1 instruction → it uses own Cond, remaining unchanged; slot-0 taken branch (PCS=1) → PCSrc=1, ITActive=0 next cycle.
- Pull RESET_N low mid-IT block with bank0=1111 → outputs 0 immediately, after release ITActive=0 and FlagsOut=0000.

Source files
------------

// File: rtl/cond_unit_banked.sv
// Banked ARM conditional-execution unit: one NZVC bank per context, gates PCSrc/RegWrite/MemWrite.
// Optional IT-style slot sequencer is built when COND_IT_EN is defined.
module cond_unit_banked #(
  parameter int NCTX   = 2,
  parameter int CTX_W  = 1,
  parameter int MAX_IT = 4
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              Valid,
  input  logic [CTX_W-1:0]  Ctx,
  input  logic [3:0]        Cond,
  input  logic [3:0]        ALUFlags,
  input  logic [1:0]        FlagW,
  input  logic              PCS,
  input  logic              RegW,
  input  logic              MemW,
  input  logic              ITStart,
  input  logic [3:0]        ITCond,
  input  logic [3:0]        ITLen,
  input  logic [MAX_IT-1:0] ITThen,
  output logic              PCSrc,
  output logic              RegWrite,
  output logic              MemWrite,
  output logic              CondEx,
  output logic              ITActive,
  output logic [3:0]        FlagsOut
);

  logic [3:0] bank [NCTX];
  logic       ctx_ok;
  logic       v_eff;
  logic       it_start;
  logic       cond_ex;
  logic       flag_we;
  logic       gate;
  logic [3:0] cur_flags;
  logic [3:0] eff_cond;

  function automatic logic cond_pass(input logic [3:0] c, input logic [3:0] f);
    logic n, z, v, cy, r;
    {n, z, v, cy} = f;
    case (c)
      4'b0000: r = z;
      4'b0001: r = ~z;
      4'b0010: r = cy;
      4'b0011: r = ~cy;
      4'b0100: r = n;
      4'b0101: r = ~n;
      4'b0110: r = v;
      4'b0111: r = ~v;
      4'b1000: r = cy & ~z;
      4'b1001: r = ~cy | z;
      4'b1010: r = ~(n ^ v);
      4'b1011: r = n ^ v;
      4'b1100: r = ~z & ~(n ^ v);
      4'b1101: r = z | (n ^ v);
      4'b1110: r = 1'b1;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  // Out-of-range contexts behave as bubbles and see an all-zero bank.
  assign ctx_ok    = (32'(Ctx) < 32'(NCTX));
  assign v_eff     = Valid & ctx_ok;
  assign cur_flags = ctx_ok ? bank[Ctx] : 4'b0000;
  assign cond_ex   = cond_pass(eff_cond, cur_flags);
  assign flag_we   = v_eff & cond_ex & ~it_start;
  assign gate      = RESET_N & flag_we;

  assign PCSrc    = gate & PCS;
  assign RegWrite = gate & RegW;
  assign MemWrite = gate & MemW;
  assign CondEx   = RESET_N & cond_ex;
  assign FlagsOut = RESET_N ? cur_flags : 4'b0000;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int i = 0; i < NCTX; i++) bank[i] <= 4'b0000;
    end else if (flag_we) begin
      if (FlagW[1]) bank[Ctx][3:2] <= ALUFlags[3:2];
      if (FlagW[0]) bank[Ctx][1:0] <= ALUFlags[1:0];
    end
  end

`ifdef COND_IT_EN
  logic [CTX_W-1:0]  it_ctx, it_ctx_n;
  logic [3:0]        it_cond, it_cond_n;
  logic [3:0]        it_rem, it_rem_n;
  logic [MAX_IT-1:0] it_mask, it_mask_n;
  logic [3:0]        len_clamp;
  logic [3:0]        slot_cond;
  logic              it_active;
  logic              it_sel;
  logic              slot_hit;

  assign it_start  = ITStart;
  assign it_active = (it_rem != 4'd0);
  assign it_sel    = it_active & (Ctx == it_ctx);
  assign slot_hit  = v_eff & it_sel & ~ITStart;
  // An inverted AL slot must become NV rather than flip back to something that passes.
  assign slot_cond = it_mask[0] ? it_cond :
                     (it_cond == 4'b1110) ? 4'b1111 : {it_cond[3:1], ~it_cond[0]};
  assign eff_cond  = it_sel ? slot_cond : Cond;
  assign len_clamp = (ITLen > 4'(MAX_IT)) ? 4'(MAX_IT) : ITLen;
  assign ITActive  = RESET_N & it_active;

  always_comb begin
    it_rem_n  = it_rem;
    it_mask_n = it_mask;
    it_cond_n = it_cond;
    it_ctx_n  = it_ctx;
    if (v_eff && ITStart) begin
      if (ITLen != 4'd0) begin
        it_rem_n  = len_clamp;
        it_mask_n = ITThen;
        it_cond_n = ITCond;
        it_ctx_n  = Ctx;
      end else begin
        it_rem_n  = 4'd0;
      end
    end else if (slot_hit) begin
      // A taken branch inside the block flushes the remaining slots.
      it_mask_n = it_mask >> 1;
      it_rem_n  = (cond_ex && PCS) ? 4'd0 : it_rem - 4'd1;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      it_rem  <= 4'd0;
      it_mask <= '0;
      it_cond <= 4'b0000;
      it_ctx  <= '0;
    end else begin
      it_rem  <= it_rem_n;
      it_mask <= it_mask_n;
      it_cond <= it_cond_n;
      it_ctx  <= it_ctx_n;
    end
  end
`else
  logic unused_it;
  assign unused_it = ^{ITStart, ITCond, ITLen, ITThen};
  assign it_start  = 1'b0;
  assign eff_cond  = Cond;
  assign ITActive  = 1'b0;
`endif

endmodule

// File: tb/tb_cond_unit_banked.sv
// Testbench for cond_unit_banked: directed vector table, IT/reset sequences and a randomized
// run against a queue-based reference model. IT checks are built when COND_IT_EN is defined.
module tb_cond_unit_banked;
  localparam int NCTX   = 2;
  localparam int CTX_W  = 1;
  localparam int MAX_IT = 4;
`ifdef COND_IT_EN
  localparam bit IT_EN = 1'b1;
`else
  localparam bit IT_EN = 1'b0;
`endif

  logic              CLK = 1'b0;
  logic              RESET_N;
  logic              Valid;
  logic [CTX_W-1:0]  Ctx;
  logic [3:0]        Cond;
  logic [3:0]        ALUFlags;
  logic [1:0]        FlagW;
  logic              PCS, RegW, MemW;
  logic              ITStart;
  logic [3:0]        ITCond;
  logic [3:0]        ITLen;
  logic [MAX_IT-1:0] ITThen;
  logic              PCSrc, RegWrite, MemWrite, CondEx, ITActive;
  logic [3:0]        FlagsOut;

  int n_checks = 0;
  int n_fails  = 0;

  // Reference model: flag banks plus a queue holding the remaining slot conditions.
  logic [3:0] m_flags [NCTX];
  logic [3:0] it_q [$];
  int         it_ctx;

  typedef struct {
    logic [CTX_W-1:0] ctx;
    logic [3:0]       cond;
    logic [3:0]       alu;
    logic [1:0]       flagw;
    logic             pcs, regw, memw;
    logic             e_condex, e_pcsrc, e_regwrite, e_memwrite;
    logic [3:0]       e_flags;
  } vec_t;
  vec_t vecs [12];

  cond_unit_banked #(.NCTX(NCTX), .CTX_W(CTX_W), .MAX_IT(MAX_IT)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .Valid(Valid), .Ctx(Ctx), .Cond(Cond),
    .ALUFlags(ALUFlags), .FlagW(FlagW), .PCS(PCS), .RegW(RegW), .MemW(MemW),
    .ITStart(ITStart), .ITCond(ITCond), .ITLen(ITLen), .ITThen(ITThen),
    .PCSrc(PCSrc), .RegWrite(RegWrite), .MemWrite(MemWrite), .CondEx(CondEx),
    .ITActive(ITActive), .FlagsOut(FlagsOut)
  );

  always #5 CLK = ~CLK;

  function automatic logic cond_passes(input logic [3:0] c, input logic [3:0] f);
    logic n, z, v, cy, r;
    {n, z, v, cy} = f;
    case (c[3:1])
      3'd0: r = z;
      3'd1: r = cy;
      3'd2: r = n;
      3'd3: r = v;
      3'd4: r = cy & ~z;
      3'd5: r = (n == v);
      3'd6: r = ~z & (n == v);
      default: r = 1'b1;
    endcase
    if (c[3:1] != 3'd7 && c[0]) r = ~r;
    if (c == 4'b1111) r = 1'b0;
    return r;
  endfunction

  function automatic logic [3:0] inv_cond(input logic [3:0] c);
    return (c == 4'b1110) ? 4'b1111 : (c ^ 4'b0001);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NCTX; i++) m_flags[i] = 4'b0000;
    it_q.delete();
    it_ctx = 0;
  endtask

  task automatic model_outputs(output logic pass, output logic pcs_o, output logic regw_o,
                               output logic memw_o, output logic itact_o, output logic [3:0] flags_o);
    logic [3:0] ec;
    logic       is_it;
    is_it   = IT_EN & ITStart;
    ec      = (it_q.size() > 0 && int'(Ctx) == it_ctx) ? it_q[0] : Cond;
    flags_o = m_flags[Ctx];
    pass    = cond_passes(ec, flags_o);
    pcs_o   = Valid & pass & PCS & ~is_it;
    regw_o  = Valid & pass & RegW & ~is_it;
    memw_o  = Valid & pass & MemW & ~is_it;
    itact_o = (it_q.size() != 0);
  endtask

  task automatic model_commit();
    logic pass, pcs_o, regw_o, memw_o, itact_o, is_it;
    logic [3:0] fl;
    int n;
    model_outputs(pass, pcs_o, regw_o, memw_o, itact_o, fl);
    is_it = IT_EN & ITStart;
    if (Valid && pass && !is_it) begin
      if (FlagW[1]) m_flags[Ctx][3:2] = ALUFlags[3:2];
      if (FlagW[0]) m_flags[Ctx][1:0] = ALUFlags[1:0];
    end
    if (Valid && is_it) begin
      it_q.delete();
      if (ITLen != 4'd0) begin
        n = (int'(ITLen) > MAX_IT) ? MAX_IT : int'(ITLen);
        for (int i = 0; i < n; i++) it_q.push_back(ITThen[i] ? ITCond : inv_cond(ITCond));
        it_ctx = int'(Ctx);
      end
    end else if (Valid && it_q.size() > 0 && int'(Ctx) == it_ctx) begin
      void'(it_q.pop_front());
      if (pcs_o) it_q.delete();
    end
  endtask

  task automatic checkOutput(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic cx, input logic pc, input logic rw,
                           input logic mw, input logic ia, input logic [3:0] fl);
    checkOutput({tag, ".CondEx"},   4'(CondEx),   4'(cx));
    checkOutput({tag, ".PCSrc"},    4'(PCSrc),    4'(pc));
    checkOutput({tag, ".RegWrite"}, 4'(RegWrite), 4'(rw));
    checkOutput({tag, ".MemWrite"}, 4'(MemWrite), 4'(mw));
    checkOutput({tag, ".ITActive"}, 4'(ITActive), 4'(ia));
    checkOutput({tag, ".FlagsOut"}, FlagsOut,     fl);
  endtask

  task automatic applyStimulus(input logic v, input logic [CTX_W-1:0] c, input logic [3:0] cd,
                               input logic [3:0] alu, input logic [1:0] fw,
                               input logic p, input logic r, input logic m);
    Valid = v; Ctx = c; Cond = cd; ALUFlags = alu; FlagW = fw;
    PCS = p; RegW = r; MemW = m;
    ITStart = 1'b0; ITCond = 4'b0000; ITLen = 4'd0; ITThen = '0;
  endtask

  task automatic apply_it(input logic [CTX_W-1:0] c, input logic [3:0] ic, input logic [3:0] len,
                          input logic [MAX_IT-1:0] th);
    applyStimulus(1'b1, c, 4'b1110, 4'b1111, 2'b11, 1'b1, 1'b1, 1'b1);
    ITStart = 1'b1; ITCond = ic; ITLen = len; ITThen = th;
  endtask

  task automatic tick();
    model_commit();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic reset_dut();
    @(negedge CLK);
    RESET_N = 1'b0;
    model_reset();
    @(negedge CLK);
    RESET_N = 1'b1;
  endtask

  initial begin
    logic pass, pc, rw, mw, ia;
    logic [3:0] fl;
    string tag;

    //           ctx   cond     alu      fw     pcs   regw  memw  cx    pc    rw    mw    flags
    vecs[0]  = '{1'b0, 4'b0000, 4'b0000, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000};
    vecs[1]  = '{1'b0, 4'b1110, 4'b0000, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0000};
    vecs[2]  = '{1'b0, 4'b1111, 4'b0000, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000};
    vecs[3]  = '{1'b0, 4'b1110, 4'b0100, 2'b11, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000};
    vecs[4]  = '{1'b0, 4'b0000, 4'b0000, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0100};
    vecs[5]  = '{1'b1, 4'b0000, 4'b0000, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000};
    vecs[6]  = '{1'b1, 4'b0001, 4'b0000, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0000};
    vecs[7]  = '{1'b0, 4'b1110, 4'b1000, 2'b11, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0100};
    vecs[8]  = '{1'b0, 4'b1011, 4'b0011, 2'b01, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'b1000};
    vecs[9]  = '{1'b0, 4'b1010, 4'b0000, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'b1011};
    vecs[10] = '{1'b0, 4'b1101, 4'b0000, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1011};
    vecs[11] = '{1'b0, 4'b1000, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'b1011};

    RESET_N = 1'b0;
    applyStimulus(1'b1, 1'b0, 4'b1110, 4'b0000, 2'b00, 1'b1, 1'b1, 1'b1);
    model_reset();
    repeat (2) @(negedge CLK);
    #1 check_all("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000);
    @(negedge CLK);
    RESET_N = 1'b1;

    for (int i = 0; i < 12; i++) begin
      applyStimulus(1'b1, vecs[i].ctx, vecs[i].cond, vecs[i].alu, vecs[i].flagw,
                    vecs[i].pcs, vecs[i].regw, vecs[i].memw);
      #1;
      tag = $sformatf("vec%0d", i);
      check_all(tag, vecs[i].e_condex, vecs[i].e_pcsrc, vecs[i].e_regwrite,
                vecs[i].e_memwrite, 1'b0, vecs[i].e_flags);
      tick();
    end

`ifdef COND_IT_EN
    reset_dut();
    applyStimulus(1'b1, 1'b0, 4'b1110, 4'b0100, 2'b11, 1'b0, 1'b0, 1'b0);
    tick();
    apply_it(1'b0, 4'b0000, 4'd3, 4'b0101);
    #1 checkOutput("it_start.RegWrite", 4'(RegWrite), 4'd0);
    checkOutput("it_start.ITActive", 4'(ITActive), 4'd0);
    tick();
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b1, 1'b0, 4'b1110, 4'b0000, 2'b00, 1'b0, 1'b1, 1'b0);
      #1 checkOutput($sformatf("it_slot%0d.RegWrite", k), 4'(RegWrite), (k == 1) ? 4'd0 : 4'd1);
      checkOutput($sformatf("it_slot%0d.ITActive", k), 4'(ITActive), 4'd1);
      tick();
    end
    applyStimulus(1'b1, 1'b0, 4'b1110, 4'b0000, 2'b00, 1'b0, 1'b1, 1'b0);
    #1 checkOutput("it_done.ITActive", 4'(ITActive), 4'd0);
    tick();

    apply_it(1'b0, 4'b0000, 4'd3, 4'b0101);
    tick();
    applyStimulus(1'b1, 1'b1, 4'b1110, 4'b0000, 2'b00, 1'b0, 1'b1, 1'b0);
    #1 checkOutput("it_other.RegWrite", 4'(RegWrite), 4'd1);
    checkOutput("it_other.ITActive", 4'(ITActive), 4'd1);
    tick();
    applyStimulus(1'b1, 1'b0, 4'b1111, 4'b0000, 2'b00, 1'b1, 1'b0, 1'b0);
    #1 checkOutput("it_branch.PCSrc", 4'(PCSrc), 4'd1);
    tick();
    applyStimulus(1'b1, 1'b0, 4'b1110, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0);
    #1 checkOutput("it_flush.ITActive", 4'(ITActive), 4'd0);
    tick();

    apply_it(1'b0, 4'b0000, 4'd9, 4'b1111);
    tick();
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1'b1, 1'b0, 4'b1111, 4'b0000, 2'b00, 1'b0, 1'b1, 1'b0);
      #1 checkOutput($sformatf("it_clamp%0d.ITActive", k), 4'(ITActive), (k < 4) ? 4'd1 : 4'd0);
      checkOutput($sformatf("it_clamp%0d.RegWrite", k), 4'(RegWrite), (k < 4) ? 4'd1 : 4'd0);
      tick();
    end
`endif

    // Asynchronous reset in the middle of an IT block with a fully set bank.
    applyStimulus(1'b1, 1'b0, 4'b1110, 4'b1111, 2'b11, 1'b0, 1'b0, 1'b0);
    tick();
`ifdef COND_IT_EN
    apply_it(1'b0, 4'b1110, 4'd4, 4'b1111);
    tick();
`endif
    applyStimulus(1'b1, 1'b0, 4'b1110, 4'b0000, 2'b00, 1'b1, 1'b1, 1'b1);
    #1 checkOutput("pre_rst.FlagsOut", FlagsOut, 4'b1111);
    RESET_N = 1'b0;
    #1 check_all("mid_rst", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000);
    model_reset();
    @(posedge CLK);
    @(negedge CLK);
    RESET_N = 1'b1;
    applyStimulus(1'b1, 1'b0, 4'b1110, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0);
    #1 check_all("post_rst", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000);
    tick();

    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom_range(0, 5) != 0), CTX_W'($urandom_range(0, NCTX - 1)),
                    4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                    2'($urandom_range(0, 3)), 1'($urandom_range(0, 3) == 0),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      ITStart = ($urandom_range(0, 7) == 0);
      ITCond  = 4'($urandom_range(0, 14));
      ITLen   = 4'($urandom_range(0, 15));
      ITThen  = MAX_IT'($urandom);
      #1;
      model_outputs(pass, pc, rw, mw, ia, fl);
      check_all($sformatf("rand%0d", i), pass, pc, rw, mw, ia, fl);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
